// File: rtl/bcd_scan_driver.sv
// Binary-to-BCD converter using a sequential double-dabble engine. It also runs a
// free-running digit scanner. Optional `BLANK_LZ_EN` keeps leading-zero digits dark.
module bcd_scan_driver #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [3:0]        digit_o,
  output logic [DIGITS-1:0] anode_n_o
);

  localparam int BCD_W  = DIGITS * 4;
  localparam int STEP_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [STEP_W-1:0] step_q, step_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic [CNT_W-1:0]  ref_q, ref_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] lit;

  // Add-3 correction per nibble, applied before each shift.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (load_i) begin
          bin_d   = value_i;
          bcd_d   = '0;
          step_d  = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};
        step_d         = step_q + 1'b1;
        if (step_q == STEP_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        disp_d  = bcd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      disp_q  <= disp_d;
    end
  end

  assign busy_o = (state_q == S_CONVERT) || (state_q == S_DONE);
  assign done_o = (state_q == S_DONE);

  // Scanner runs regardless of the conversion FSM.
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == CNT_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : (idx_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
    end
  end

  // A digit is lit unless it sits above the most significant non-zero nibble.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lit
`ifdef BLANK_LZ_EN
    if (gi == 0) begin : g_d0
      assign lit[gi] = 1'b1;
    end else begin : g_dn
      assign lit[gi] = |disp_q[BCD_W-1:gi*4];
    end
`else
    assign lit[gi] = 1'b1;
`endif
  end

  always_comb begin
    digit_o   = 4'd0;
    anode_n_o = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_o      = disp_q[i*4 +: 4];
        anode_n_o[i] = ~lit[i];
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver (WIDTH=8, DIGITS=3, REFRESH_DIV=4); follows the
// BLANK_LZ_EN build option in its expected anode patterns.
module tb_bcd_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] value_i = 8'd0;
  logic       load_i = 1'b0;
  logic       busy_o, done_o;
  logic [3:0] digit_o;
  logic [2:0] anode_n_o;

  int errors = 0;
  int checks = 0;
  int cyc;

  bcd_scan_driver #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i),
    .busy_o(busy_o), .done_o(done_o), .digit_o(digit_o), .anode_n_o(anode_n_o)
  );

  always #5 clk = ~clk;

  // Edges since reset release; scan index is expected at (cyc/4)%3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic int dig(input int v, input int k);
    return (v / pow10(k)) % 10;
  endfunction

  function automatic logic [2:0] exp_anode(input int v, input int k);
    logic [2:0] a = 3'b111;
    bit lit = 1'b1;
`ifdef BLANK_LZ_EN
    lit = (k == 0) || (v >= pow10(k));
`endif
    if (lit) a[k] = 1'b0;
    return a;
  endfunction

  // Walk one scan frame and check each digit/anode pair.
  task automatic show(input int v);
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while ((((cyc / 4) % 3) != k) && (n < 30)) begin
        @(negedge clk);
        n++;
      end
      if (n >= 30) chk("scan_timeout", 1, 0);
      chk("digit", digit_o, dig(v, k));
      chk("anode", anode_n_o, exp_anode(v, k));
    end
    $display("frame value=%0d checked", v);
  endtask

  // Pulse load, then follow busy/done and confirm the old value stays displayed.
  task automatic do_load(input int v, input int old);
    value_i = 8'(v);
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk("busy", busy_o, (k <= 9) ? 1 : 0);
      chk("done", done_o, (k == 9) ? 1 : 0);
      chk("hold_digit", digit_o, dig((k <= 9) ? old : v, (cyc / 4) % 3));
      if (k < 10) @(negedge clk);
    end
    $display("load value=%0d busy/done sequence checked", v);
  endtask

  initial begin
    int dcount;

    // Reset state and idle scan sequence
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_digit", digit_o, 0);
    chk("rst_anode", anode_n_o, exp_anode(0, 0));
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      int t = 0;
      while ((cyc != 4 * n) && (t < 20)) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) chk("scan_timeout", 1, 0);
      chk("idle_scan", anode_n_o, exp_anode(0, n % 3));
    end
    $display("reset and idle scan checked");

    do_load(237, 0);
    show(237);
    do_load(255, 237);
    show(255);
    do_load(0, 255);
    show(0);

    // Load arriving while busy is dropped
    value_i = 8'd237;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    value_i = 8'd10;
    load_i  = 1'b1;
    dcount  = 0;
    @(negedge clk);
    load_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_o) dcount++;
      @(negedge clk);
    end
    chk("busy_ignore_done_count", dcount, 1);
    $display("load while busy ignored, done pulses=%0d", dcount);
    show(237);

    // Reset during conversion
    value_i = 8'd99;
    load_i  = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_digit", digit_o, 0);
    chk("midrst_anode", anode_n_o, exp_anode(0, 0));
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_o) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    $display("reset mid-conversion checked");
    show(0);

    do_load(7, 0);
    show(7);
    do_load(105, 7);
    show(105);
    do_load(0, 105);
    show(0);

    // Held load re-triggers on each return to idle
    value_i = 8'd255;
    load_i  = 1'b1;
    dcount  = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (done_o) dcount++;
    end
    load_i = 1'b0;
    chk("retrigger_done_count", dcount, 2);
    repeat (15) @(negedge clk);
    chk("retrigger_idle", busy_o, 0);
    $display("held load retrigger, done pulses=%0d", dcount);
    show(255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
